// File: rtl/audio_pkg.sv
// Shared types and constants for the clip record/playback controller.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REC       = 2'd1,
    ST_PLAY      = 2'd2,
    ST_PLAY_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;

  localparam int CMD_ABORT   = 4;
  localparam int CMD_REC     = 3;
  localparam int CMD_PLAY    = 2;
  localparam int CMD_CLIP_WR = 1;
  localparam int CMD_CLIP_RD = 0;

  // PLAY and PLAY_WAIT share one LED encoding.
  function automatic logic [1:0] state_to_mode(state_e s);
    case (s)
      ST_REC:                state_to_mode = MODE_REC;
      ST_PLAY, ST_PLAY_WAIT: state_to_mode = MODE_PLAY;
      default:               state_to_mode = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector against the registered previous level.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/clip_controller.sv
// Two-clip audio record/playback controller driving an external clip RAM
// with one-cycle read latency.
module clip_controller
  import audio_pkg::*;
#(
  parameter int CLIP_DEPTH = 4096,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        cmd,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] mic_data,
  output logic [$clog2(CLIP_DEPTH):0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] spk_data,
  output logic              spk_valid,
  output logic [1:0]        mode,
  output logic              done
);

  localparam int ADDR_W = $clog2(CLIP_DEPTH);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(CLIP_DEPTH);

  state_e                  state_q, state_d;
  logic                    clip_q, clip_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0][ADDR_W:0]    len_q, len_d;
  logic [DATA_W-1:0]       spk_data_q, spk_data_d;
  logic                    spk_valid_q, spk_valid_d;
  logic                    done_q, done_d;

  logic                    rec_edge, play_edge, abort;
  logic [ADDR_W:0]         rd_cnt_next;

  rise_detect u_rec_edge (
    .clock (clock),
    .reset (reset),
    .d_i   (cmd[CMD_REC]),
    .rise_o(rec_edge)
  );

  rise_detect u_play_edge (
    .clock (clock),
    .reset (reset),
    .d_i   (cmd[CMD_PLAY]),
    .rise_o(play_edge)
  );

  assign abort       = cmd[CMD_ABORT];
  assign rd_cnt_next = {1'b0, rd_ptr_q} + (ADDR_W+1)'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clip_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      spk_data_q  <= '0;
      spk_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clip_q      <= clip_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      spk_data_q  <= spk_data_d;
      spk_valid_q <= spk_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clip_d      = clip_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    spk_data_d  = spk_data_q;
    spk_valid_d = 1'b0;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    if (abort) begin
      // A partial recording is kept up to the last completed write.
      state_d = ST_IDLE;
      if (state_q != ST_IDLE) done_d = 1'b1;
      if (state_q == ST_REC)  len_d[clip_q] = {1'b0, wr_ptr_q};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rec_edge) begin
            state_d  = ST_REC;
            clip_d   = cmd[CMD_CLIP_WR];
            wr_ptr_d = '0;
          end else if (play_edge) begin
            state_d  = ST_PLAY;
            clip_d   = cmd[CMD_CLIP_RD];
            rd_ptr_d = '0;
          end
        end
        ST_REC: begin
          if (rec_edge) begin
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            len_d[clip_q] = {1'b0, wr_ptr_q};
          end else if (sample_tick) begin
            mem_we    = 1'b1;
            mem_wdata = mic_data;
            if (wr_ptr_q == '1) begin
              state_d       = ST_IDLE;
              done_d        = 1'b1;
              len_d[clip_q] = LEN_FULL;
            end else begin
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (len_q[clip_q] == '0 || play_edge) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (sample_tick) begin
            state_d = ST_PLAY_WAIT;
          end
        end
        ST_PLAY_WAIT: begin
          // The read issued in PLAY always lands, even when stopping.
          spk_data_d  = mem_rdata;
          spk_valid_d = 1'b1;
          if (play_edge || rd_cnt_next == len_q[clip_q]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_PLAY;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE: mem_addr = '0;
      ST_REC:  mem_addr = {clip_q, wr_ptr_q};
      default: mem_addr = {clip_q, rd_ptr_q};
    endcase
  end

  assign spk_data  = spk_data_q;
  assign spk_valid = spk_valid_q;
  assign done      = done_q;
  assign mode      = state_to_mode(state_q);

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with a one-cycle-latency RAM model.
module tb_clip_controller;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    cmd;
  logic          sample_tick;
  logic [DW-1:0] mic_data;
  logic [4:0]    mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] spk_data;
  logic          spk_valid;
  logic [1:0]    mode;
  logic          done;

  clip_controller #(.CLIP_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd),
    .sample_tick(sample_tick),
    .mic_data   (mic_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .spk_data   (spk_data),
    .spk_valid  (spk_valid),
    .mode       (mode),
    .done       (done)
  );

  always #5 clock = ~clock;

  // RAM model: synchronous write, registered read (data one cycle after address)
  logic [DW-1:0] ram [0:31];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Event log
  int          wr_addr_q [$];
  int          wr_data_q [$];
  int          spk_q [$];
  int          done_cnt;
  int          valid_at_done;
  always @(posedge clock) begin
    if (!reset) begin
      if (mem_we)    begin wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata); end
      if (spk_valid) spk_q.push_back(spk_data);
      if (done)      begin done_cnt++; valid_at_done = spk_q.size(); end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); spk_q.delete();
    done_cnt = 0; valid_at_done = -1;
  endtask

  // Hold tick high until done is seen or the budget runs out.
  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done_cnt != d0) begin seen = 1; break; end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic start_play(input logic clip);
    cmd = {3'b001, 1'b0, clip}; sample_tick = 1'b0; cyc();
    cmd = 5'b0; sample_tick = 1'b1;
  endtask

  typedef struct {
    logic [4:0] cmd; logic tick; logic [7:0] mic;
    logic we; logic [4:0] addr; logic [7:0] wdata; logic [1:0] mode; logic done;
  } vec_t;

  function automatic vec_t mk(logic [4:0] c, logic t, logic [7:0] m,
                              logic w, logic [4:0] a, logic [7:0] wd, logic [1:0] md, logic dn);
    vec_t v;
    v.cmd = c; v.tick = t; v.mic = m; v.we = w; v.addr = a; v.wdata = wd; v.mode = md; v.done = dn;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    // Record clip 1: five samples 0x10..0x14, one idle tick-free cycle, stop on rec edge.
    tbl[0]  = mk(5'b00000, 0, 8'h00, 0, 5'h00, 8'h00, 2'd0, 0);
    tbl[1]  = mk(5'b01010, 0, 8'h00, 0, 5'h00, 8'h00, 2'd0, 0);
    tbl[2]  = mk(5'b01010, 1, 8'h10, 1, 5'h10, 8'h10, 2'd1, 0);
    tbl[3]  = mk(5'b01010, 1, 8'h11, 1, 5'h11, 8'h11, 2'd1, 0);
    tbl[4]  = mk(5'b01010, 0, 8'h55, 0, 5'h12, 8'h00, 2'd1, 0);
    tbl[5]  = mk(5'b01010, 1, 8'h12, 1, 5'h12, 8'h12, 2'd1, 0);
    tbl[6]  = mk(5'b00000, 1, 8'h13, 1, 5'h13, 8'h13, 2'd1, 0);
    tbl[7]  = mk(5'b00100, 1, 8'h14, 1, 5'h14, 8'h14, 2'd1, 0);
    tbl[8]  = mk(5'b00000, 0, 8'h00, 0, 5'h15, 8'h00, 2'd1, 0);
    tbl[9]  = mk(5'b01000, 1, 8'h99, 0, 5'h15, 8'h00, 2'd1, 0);
    tbl[10] = mk(5'b00000, 0, 8'h00, 0, 5'h00, 8'h00, 2'd0, 1);
    tbl[11] = mk(5'b00000, 1, 8'h77, 0, 5'h00, 8'h00, 2'd0, 0);

    reset = 1'b1; cmd = 5'b0; sample_tick = 1'b0; mic_data = '0;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    clear_log();
    #12;
    chk("rst_mode", mode, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_spk_data", spk_data, 0);
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_done", done, 0);
    cyc(); reset = 1'b0; cyc();

    // Play clip 0 with nothing recorded
    clear_log();
    start_play(1'b0);
    wait_done("empty_play0", 5);
    chk("empty_play0_done_cnt", done_cnt, 1);
    chk("empty_play0_valid", spk_q.size(), 0);
    sample_tick = 1'b0; cyc();

    // Table-driven record of clip 1
    clear_log();
    for (int i = 0; i < 12; i++) begin
      cmd = tbl[i].cmd; sample_tick = tbl[i].tick; mic_data = tbl[i].mic;
      @(negedge clock);
      chk($sformatf("v%0d_we", i),    mem_we,    tbl[i].we);
      chk($sformatf("v%0d_addr", i),  mem_addr,  tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("v%0d_mode", i),  mode,      tbl[i].mode);
      chk($sformatf("v%0d_done", i),  done,      tbl[i].done);
      cyc();
    end
    chk("rec1_writes", wr_addr_q.size(), 5);
    chk("rec1_done_cnt", done_cnt, 1);
    sample_tick = 1'b0; cmd = 5'b0;

    // Play clip 1
    clear_log();
    start_play(1'b1);
    wait_done("play1", 40);
    chk("play1_count", spk_q.size(), 5);
    for (int k = 0; k < 5 && k < spk_q.size(); k++)
      chk($sformatf("play1_s%0d", k), spk_q[k], 8'h10 + k);
    chk("play1_done_after_5th", valid_at_done, 5);
    sample_tick = 1'b0; cyc(); cyc();
    chk("play1_done_once", done_cnt, 1);
    chk("play1_spk_held", spk_data, 8'h14);

    // Record clip 0 with 20 ticks: fills at 16
    clear_log();
    cmd = 5'b01000; cyc(); cmd = 5'b0;
    for (int i = 0; i < 20; i++) begin
      sample_tick = 1'b1; mic_data = 8'(8'hA0 + i); cyc();
    end
    sample_tick = 1'b0; cyc();
    chk("full_writes", wr_addr_q.size(), 16);
    for (int k = 0; k < 16 && k < wr_addr_q.size(); k++) begin
      chk($sformatf("full_addr%0d", k), wr_addr_q[k], k);
      chk($sformatf("full_data%0d", k), wr_data_q[k], 8'hA0 + k);
    end
    chk("full_done_cnt", done_cnt, 1);
    chk("full_mode", mode, 0);

    clear_log();
    start_play(1'b0);
    wait_done("play0_full", 60);
    chk("play0_full_count", spk_q.size(), 16);
    if (spk_q.size() == 16) chk("play0_full_last", spk_q[15], 8'hAF);
    sample_tick = 1'b0; cyc();

    // Simultaneous rec/play edges, then abort after 3 writes
    clear_log();
    cmd = 5'b01111; cyc();
    @(negedge clock);
    chk("both_edges_mode", mode, 1);
    cmd = 5'b0;
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1'b1; mic_data = 8'(8'hC0 + i); cyc();
    end
    sample_tick = 1'b1; mic_data = 8'hEE; cmd = 5'b10000; cyc();
    sample_tick = 1'b0; cmd = 5'b0;
    @(negedge clock);
    chk("abort_mode", mode, 0);
    chk("abort_done", done, 1);
    chk("abort_writes", wr_addr_q.size(), 3);
    cyc();

    clear_log();
    start_play(1'b1);
    wait_done("play_abort_len", 30);
    chk("abort_len_count", spk_q.size(), 3);
    if (spk_q.size() == 3) chk("abort_len_last", spk_q[2], 8'hC2);
    sample_tick = 1'b0; cyc();

    // Async reset in the middle of playback
    clear_log();
    start_play(1'b1);
    cyc(); cyc(); cyc();
    #2;
    chk("pre_rst_mode", mode, 2);
    reset = 1'b1;
    #1;
    chk("async_mode", mode, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_spk_data", spk_data, 0);
    chk("async_spk_valid", spk_valid, 0);
    chk("async_done", done, 0);
    chk("async_we", mem_we, 0);
    sample_tick = 1'b0; cmd = 5'b0;
    cyc(); reset = 1'b0; cyc();
    clear_log();
    start_play(1'b1);
    wait_done("post_rst_play1", 5);
    chk("post_rst_len0", spk_q.size(), 0);
    sample_tick = 1'b0; cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clip_controller.md
CLIP_CONTROLLER -- requirements
Module: clip_controller

Interface
REQ-001 SHALL have parameter CLIP_DEPTH, default 4096, samples per clip (power of two, >=4).
REQ-002 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-003 SHALL derive localparam ADDR_W = log2(CLIP_DEPTH).
REQ-004 SHALL have port clock  in  1  single clock; all state on posedge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port cmd  in  5  synchronized command word {abort, record, play, clip_wr, clip_rd}, bits 4..0.
REQ-007 SHALL have port sample_tick  in  1  one-cycle audio-rate strobe.
REQ-008 SHALL have port mic_data  in  DATA_W  sample to record.
REQ-009 SHALL have port mem_addr  out  ADDR_W+1  {clip, offset} to clip RAM.
REQ-010 SHALL have port mem_we  out  1  RAM write strobe.
REQ-011 SHALL have port mem_wdata  out  DATA_W  RAM write data.
REQ-012 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after address.
REQ-013 SHALL have port spk_data  out  DATA_W  last played sample (held).
REQ-014 SHALL have port spk_valid  out  1  one-cycle pulse when spk_data updates.
REQ-015 SHALL have port mode  out  2  current state encoding for LEDs.
REQ-016 SHALL have port done  out  1  one-cycle pulse on any return to IDLE from REC or PLAY.

Function
REQ-017 SHALL implement FSM states IDLE, REC, PLAY, PLAY_WAIT.
REQ-018 SHALL detect rising edges of cmd[3] (rec_edge) and cmd[2] (play_edge) against registered previous values; levels never start operations.
REQ-019 IDLE: rec_edge -> REC, latch clip = cmd[1], wr_ptr = 0; else play_edge -> PLAY, latch clip = cmd[0], rd_ptr = 0; rec_edge and play_edge together -> record wins.
REQ-020 PLAY entry with len[clip] == 0 SHALL pulse done and return to IDLE next cycle, no RAM read.
REQ-021 REC: on sample_tick SHALL assert mem_we for that cycle with mem_addr = {clip, wr_ptr}, mem_wdata = mic_data, then increment wr_ptr.
REQ-022 REC: write at wr_ptr == CLIP_DEPTH-1 SHALL set len[clip] = CLIP_DEPTH, pulse done, go IDLE (full boundary).
REQ-023 REC: rec_edge SHALL stop: len[clip] = wr_ptr, done, IDLE; a coincident sample_tick is not written.
REQ-024 REC: play_edge SHALL be ignored.
REQ-025 PLAY: on sample_tick SHALL drive mem_addr = {clip, rd_ptr}, go PLAY_WAIT.
REQ-026 PLAY_WAIT: SHALL capture mem_rdata into spk_data, pulse spk_valid, increment rd_ptr; if rd_ptr was len[clip]-1 pulse done and go IDLE, else PLAY.
REQ-027 PLAY/PLAY_WAIT: play_edge SHALL stop playback (done, IDLE) after completing any outstanding PLAY_WAIT capture; rec_edge ignored.
REQ-028 cmd[4] high in any state SHALL abort to IDLE next cycle, pulse done if leaving REC/PLAY/PLAY_WAIT, set len[clip] = wr_ptr if leaving REC; highest priority.
REQ-029 mem_we SHALL be 0 outside REC; mem_addr SHALL hold {clip, pointer} of current state, {0,0} in IDLE.
REQ-030 sample_tick in IDLE SHALL have no effect; ticks in PLAY_WAIT SHALL be dropped.
REQ-031 len[0], len[1] SHALL be ADDR_W+1 bits (range 0..CLIP_DEPTH); pointers ADDR_W bits, never wrap.
REQ-032 mode SHALL encode IDLE=0, REC=1, PLAY and PLAY_WAIT=2.

Reset
REQ-033 reset SHALL asynchronously force IDLE, pointers 0, len[0]=len[1]=0, edge registers 0, spk_data 0, and all outputs 0.
REQ-034 reset asserted mid-REC SHALL discard the partial clip length (len stays 0 or its prior reset value 0).

Structure
REQ-035 State enum, mode encodings and cmd bit index constants SHALL live in shared package audio_pkg.
REQ-036 Rising-edge detection SHALL be one sub-module rise_detect instantiated twice.

Verification (CLIP_DEPTH=16, DATA_W=8)
REQ-037 record clip 1, 5 ticks mic_data 0x10..0x14, rec_edge -> writes addr 0x10..0x14, len[1]=5, one done.
REQ-038 play clip 1 after REQ-037, RAM model 1-cycle -> spk_data 0x10..0x14 with 5 spk_valid pulses, done after fifth.
REQ-039 record clip 0 with 20 ticks -> 16 writes (0x00..0x0F), done on 16th, ticks 17-20 no writes, len[0]=16.
REQ-040 play clip 0 with len 0 after reset -> done next cycle, no spk_valid, no read.
REQ-041 rec_edge and play_edge same cycle in IDLE -> REC entered; cmd[4] pulse during REC after 3 writes -> IDLE, len=3, done.
REQ-042 async reset asserted mid-PLAY between clock edges -> outputs 0 immediately, len 0, IDLE.
